// File: rtl/lsu_bus_bridge.sv
// Load/store unit to single-beat bus bridge: aligns stores, extracts and extends loads,
// enforces alignment and bounds the bus wait with a timeout.
module lsu_bus_bridge #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        SYS_clk,
  input  logic        SYS_reset,
  input  logic [1:0]  MEM_write_length,
  input  logic [1:0]  MEM_read_length,
  input  logic        MEM_read_signed,
  input  logic        LSU_read_req,
  input  logic [31:0] MEM_write_address,
  input  logic [31:0] MEM_write_data,
  input  logic [31:0] MEM_read_address,
  output logic [31:0] MEM_read_data,
  output logic        LSU_stall,
  output logic        LSU_misaligned,
  output logic        BUS_error,
  output logic        BUS_req,
  output logic        BUS_we,
  output logic [31:0] BUS_addr,
  output logic [3:0]  BUS_be,
  output logic [31:0] BUS_wdata,
  input  logic        BUS_ack,
  input  logic [31:0] BUS_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

  localparam logic [32:0] TMO = {1'b0, 32'(TIMEOUT_CYCLES)};

  state_t      state, state_n;
  logic [31:0] wait_cnt;
  logic        is_load, ld_sgn;
  logic [1:0]  ld_len, ld_off;

  logic        store_req, load_req, req, mis, accept, fault, ack_hit, tmo;
  logic [1:0]  acc_len;
  logic [31:0] acc_addr, st_wdata, ld_shift, ld_ext;
  logic [3:0]  st_be;

  // A store request shadows a simultaneous load; a zero load size means word.
  always_comb begin
    store_req = MEM_write_length != 2'b00;
    load_req  = LSU_read_req && !store_req;
    req       = store_req || load_req;
    acc_len   = store_req ? MEM_write_length
              : (MEM_read_length == 2'b00 ? 2'b11 : MEM_read_length);
    acc_addr  = store_req ? MEM_write_address : MEM_read_address;
    mis       = (acc_len == 2'b10 && acc_addr[0]) ||
                (acc_len == 2'b11 && acc_addr[1:0] != 2'b00);
    accept    = state == S_IDLE && req && !mis;
    fault     = state == S_IDLE && req && mis;
    ack_hit   = state == S_BUS && BUS_ack;
    tmo       = state == S_BUS && !BUS_ack && ({1'b0, wait_cnt} + 33'd1 >= TMO);
  end

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = MEM_write_data;
    case (MEM_write_length)
      2'b01: begin
        st_be    = 4'b0001 << MEM_write_address[1:0];
        st_wdata = {4{MEM_write_data[7:0]}};
      end
      2'b10: begin
        st_be    = 4'b0011 << {MEM_write_address[1], 1'b0};
        st_wdata = {2{MEM_write_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_shift = BUS_rdata >> {ld_off, 3'b000};
    case (ld_len)
      2'b01:   ld_ext = {{24{ld_sgn & ld_shift[7]}}, ld_shift[7:0]};
      2'b10:   ld_ext = {{16{ld_sgn & ld_shift[15]}}, ld_shift[15:0]};
      default: ld_ext = ld_shift;
    endcase
  end

  always_ff @(posedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) state <= S_IDLE;
    else           state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (accept) state_n = S_BUS;
      S_BUS:   if (ack_hit || tmo) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Stall is gated by reset so every output reads 0 while reset is held.
  assign LSU_stall = !SYS_reset && (accept || state == S_BUS);

  always_ff @(posedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      wait_cnt       <= '0;
      is_load        <= 1'b0;
      ld_sgn         <= 1'b0;
      ld_len         <= 2'b00;
      ld_off         <= 2'b00;
      MEM_read_data  <= '0;
      LSU_misaligned <= 1'b0;
      BUS_error      <= 1'b0;
      BUS_req        <= 1'b0;
      BUS_we         <= 1'b0;
      BUS_addr       <= '0;
      BUS_be         <= '0;
      BUS_wdata      <= '0;
    end else begin
      LSU_misaligned <= fault;
      BUS_error      <= tmo;
      if (accept) begin
        wait_cnt  <= '0;
        is_load   <= load_req;
        ld_sgn    <= MEM_read_signed;
        ld_len    <= acc_len;
        ld_off    <= acc_addr[1:0];
        BUS_req   <= 1'b1;
        BUS_we    <= store_req;
        BUS_addr  <= {acc_addr[31:2], 2'b00};
        BUS_be    <= store_req ? st_be : 4'b1111;
        BUS_wdata <= store_req ? st_wdata : 32'd0;
      end
      if (fault && load_req) MEM_read_data <= '0;
      if (ack_hit) begin
        BUS_req <= 1'b0;
        if (is_load) MEM_read_data <= ld_ext;
      end else if (tmo) begin
        BUS_req <= 1'b0;
        if (is_load) MEM_read_data <= '0;
      end else if (state == S_BUS) begin
        wait_cnt <= wait_cnt + 32'd1;
      end
    end
  end

endmodule

// File: doc/lsu_bus_bridge.md
LSU_BUS_BRIDGE -- requirements
Module: lsu_bus_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: max bus-wait cycles before abort.
REQ-002 SHALL have port SYS_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port SYS_reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port MEM_write_length  input  2  store size: 00 none, 01 byte, 10 half, 11 word.
REQ-005 SHALL have port MEM_read_length  input  2  load size: 01 byte, 10 half, 11 word; 00 treated as word.
REQ-006 SHALL have port MEM_read_signed  input  1  1 = sign-extend load result, 0 = zero-extend.
REQ-007 SHALL have port LSU_read_req  input  1  load request qualifier.
REQ-008 SHALL have ports MEM_write_address, MEM_write_data, MEM_read_address  input  32 each  store address, store data, load address.
REQ-009 SHALL have port MEM_read_data  output  32  registered, extended load result.
REQ-010 SHALL have port LSU_stall  output  1  holds the CPU PC while an access is pending.
REQ-011 SHALL have ports LSU_misaligned and BUS_error  output  1 each  one-cycle fault pulses.
REQ-012 SHALL have bus outputs BUS_req 1, BUS_we 1, BUS_addr 32 (bits [1:0] always 00), BUS_be 4, BUS_wdata 32.
REQ-013 SHALL have bus inputs BUS_ack 1 and BUS_rdata 32.

Function
REQ-014 SHALL implement states IDLE, BUS, DONE.
REQ-015 Request SHALL mean MEM_write_length!=00 (store) or LSU_read_req=1 (load); store wins if both, load dropped.
REQ-016 Misaligned SHALL mean half with addr[0]=1, or word with addr[1:0]!=00.
REQ-017 IDLE, aligned request: latch address/data/size/sign, go to BUS; BUS_req=1 from the next cycle.
REQ-018 IDLE, misaligned request: no bus access; LSU_misaligned=1 next cycle for 1 cycle; MEM_read_data=0 for loads; state stays IDLE.
REQ-019 LSU_stall SHALL be combinational: 1 when an aligned request is present in IDLE or state is BUS; 0 in DONE and otherwise.
REQ-020 In BUS, BUS_req/we/addr/be/wdata SHALL stay stable until BUS_ack is sampled 1, then BUS_req=0 next cycle and go to DONE.
REQ-021 DONE SHALL last exactly 1 cycle, then return to IDLE; a new request is accepted in IDLE only.
REQ-022 Minimum latency: accept edge -> BUS_req, ack edge -> DONE; total 3 cycles with a 0-wait-state bus.
REQ-023 Byte store: BUS_be=0001<<addr[1:0]; BUS_wdata = data[7:0] replicated ×4.
REQ-024 Half store: BUS_be=0011<<(2*addr[1]); BUS_wdata = data[15:0] replicated ×2.
REQ-025 Word store: BUS_be=1111; BUS_wdata = data.
REQ-026 Loads SHALL drive BUS_we=0 and BUS_be=1111.
REQ-027 On ack, load data SHALL be BUS_rdata>>(8*addr[1:0]), cut to 8/16/32 bits, sign- or zero-extended to 32.
REQ-028 Load data SHALL be registered into MEM_read_data at the ack edge and held until the next load completes or faults.
REQ-029 A 32-bit-safe wait counter SHALL increment each BUS cycle without ack.
REQ-030 If the count reaches TIMEOUT_CYCLES: drop BUS_req, pulse BUS_error 1 cycle, MEM_read_data=0 for loads, go to DONE.
REQ-031 If ack and timeout coincide, ack SHALL win and BUS_error SHALL stay 0.
REQ-032 BUS_ack in IDLE or DONE SHALL be ignored.

Reset
REQ-033 SYS_reset=1 SHALL immediately force IDLE, wait counter=0, and all outputs to 0, including MEM_read_data, BUS_*, LSU_stall, and fault pulses.
REQ-034 Reset during BUS SHALL abort the transaction with BUS_req dropping asynchronously; the access is not replayed after reset.

Verification
REQ-035 Word store, addr 0x100, data 0xDEADBEEF, ack after 2 waits -> BUS_addr 0x100, be 1111, we 1; stall high 4 cycles; no faults.
REQ-036 Byte load signed, addr 0x203, rdata 0x80FF1234 -> be 1111, MEM_read_data 0xFFFFFF80; same with signed=0 -> 0x00000080.
REQ-037 Half store, addr 0x302, data 0x0000ABCD -> BUS_addr 0x300, be 1100, wdata 0xABCDABCD.
REQ-038 Word load at 0x401 -> no BUS_req, LSU_misaligned 1-cycle pulse, MEM_read_data 0, stall low.
REQ-039 Load with ack never asserted, TIMEOUT_CYCLES=4 -> BUS_req high 4 cycles, then BUS_error pulse, MEM_read_data 0, IDLE after DONE.
REQ-040 Reset asserted mid-BUS -> BUS_req 0 without waiting for a clock edge; next request after reset runs normally.
